// File: rtl/instruction_fetch.sv
// instruction_fetch: ARMv8 fetch stage.
// This module owns the program counter, drives the instruction-memory request,
// and loads the IF/ID pipeline register.
// A one-entry hold buffer captures a word that returns while the stage is stalled.
// Optional feature: define IFETCH_PERF_EN to build the fetched/bubble/flush
// counters and their output ports.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [63:0] branch_target,
  output logic [63:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [63:0] if_id_pc,
  output logic [63:0] if_id_pc_plus4,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_flushes
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } state_e;

  localparam logic [63:0] RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ifIdPc_q, ifIdPc_d;
  logic [31:0] ifIdInstr_q, ifIdInstr_d;
  logic        ifIdValid_q, ifIdValid_d;
  logic [63:0] holdPc_q, holdPc_d;
  logic [31:0] holdInstr_q, holdInstr_d;
  logic        loadValid;
  logic        bubble;
  logic [63:0] pcPlus4;
  logic        unusedTargetBits;

  // The two low target bits are dropped because instructions are word aligned.
  assign unusedTargetBits = ^branch_target[1:0];

  assign pcPlus4           = pc_q + 64'd4;
  assign imem_addr         = pc_q;
  assign imem_req          = reset && (state_q == RUN);
  assign if_id_pc          = ifIdPc_q;
  assign if_id_pc_plus4    = ifIdPc_q + 64'd4;
  assign if_id_instruction = ifIdInstr_q;
  assign if_id_valid       = ifIdValid_q;

  // Register the state, the PC, IF/ID and the hold buffer; reset drops everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC_ALIGNED;
      ifIdPc_q    <= 64'h0;
      ifIdInstr_q <= 32'h0;
      ifIdValid_q <= 1'b0;
      holdPc_q    <= 64'h0;
      holdInstr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ifIdPc_q    <= ifIdPc_d;
      ifIdInstr_q <= ifIdInstr_d;
      ifIdValid_q <= ifIdValid_d;
      holdPc_q    <= holdPc_d;
      holdInstr_q <= holdInstr_d;
    end
  end

  // Next-state logic: a redirect beats a stall, and a stall beats normal fetch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifIdPc_d    = ifIdPc_q;
    ifIdInstr_d = ifIdInstr_q;
    ifIdValid_d = ifIdValid_q;
    holdPc_d    = holdPc_q;
    holdInstr_d = holdInstr_q;
    loadValid   = 1'b0;
    bubble      = 1'b0;
    if (PCSrc) begin
      pc_d        = {branch_target[63:2], 2'b00};
      ifIdValid_d = 1'b0;
      state_d     = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (!stall) begin
            if (imem_ready) begin
              ifIdPc_d    = pc_q;
              ifIdInstr_d = imem_rdata;
              ifIdValid_d = 1'b1;
              pc_d        = pcPlus4;
              loadValid   = 1'b1;
            end else begin
              ifIdValid_d = 1'b0;
              bubble      = 1'b1;
            end
          end else if (imem_ready) begin
            holdPc_d    = pc_q;
            holdInstr_d = imem_rdata;
            pc_d        = pcPlus4;
            state_d     = HELD;
          end
        end
        HELD: begin
          if (!stall) begin
            ifIdPc_d    = holdPc_q;
            ifIdInstr_d = holdInstr_q;
            ifIdValid_d = 1'b1;
            state_d     = RUN;
            loadValid   = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetched_q, bubbles_q, flushes_q;

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
  assign perf_flushes = flushes_q;

  // Count valid IF/ID loads, bubble cycles and redirects; each counter wraps freely.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetched_q <= 32'h0;
      bubbles_q <= 32'h0;
      flushes_q <= 32'h0;
    end else begin
      if (loadValid) fetched_q <= fetched_q + 32'd1;
      if (bubble)    bubbles_q <= bubbles_q + 32'd1;
      if (PCSrc)     flushes_q <= flushes_q + 32'd1;
    end
  end
`else
  logic unusedPerfFlags;
  assign unusedPerfFlags = loadValid ^ bubble;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized, scoreboarded bench for instruction_fetch.
// Define IFETCH_PERF_EN to also check the performance counters.
module tb_instruction_fetch;

  localparam logic [63:0] RESET_PC = 64'h400;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [63:0] if_id_pc;
  logic [63:0] if_id_pc_plus4;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_flushes;
`endif

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .PCSrc(PCSrc),
    .branch_target(branch_target),
    .imem_addr(imem_addr),
    .imem_req(imem_req),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_instruction(if_id_instruction),
    .if_id_valid(if_id_valid)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles),
    .perf_flushes(perf_flushes)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic        req;
    logic [63:0] ifPc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] fetched;
    logic [31:0] bubbles;
    logic [31:0] flushes;
  } snap_t;

  snap_t expQ[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state: a PC, the IF/ID contents, and a queue of at most one held word.
  logic [63:0] mPc;
  logic [63:0] mIfPc;
  logic [31:0] mInstr;
  logic        mValid;
  logic [95:0] holdQ[$];
  logic        mInReset;
  logic [31:0] mFetched, mBubbles, mFlushes;

  // Compare one observed value against the value the model requires.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic snap_t modelSnap();
    snap_t s;
    s.pc      = mPc;
    s.req     = !mInReset && (holdQ.size() == 0);
    s.ifPc    = mIfPc;
    s.instr   = mInstr;
    s.valid   = mValid;
    s.fetched = mFetched;
    s.bubbles = mBubbles;
    s.flushes = mFlushes;
    return s;
  endfunction

  task automatic modelReset();
    mPc      = RESET_PC;
    mIfPc    = 64'h0;
    mInstr   = 32'h0;
    mValid   = 1'b0;
    holdQ.delete();
    mFetched = 0;
    mBubbles = 0;
    mFlushes = 0;
  endtask

  // Advance the model by one clock using the fetch rules directly.
  task automatic modelStep(input logic s, input logic br, input logic [63:0] tgt,
                           input logic rdy, input logic [31:0] data);
    logic [95:0] held;
    if (br) begin
      mPc    = tgt & ~64'd3;
      mValid = 1'b0;
      holdQ.delete();
      mFlushes++;
    end else if (holdQ.size() != 0) begin
      if (!s) begin
        held   = holdQ.pop_front();
        mIfPc  = held[95:32];
        mInstr = held[31:0];
        mValid = 1'b1;
        mFetched++;
      end
    end else if (!s) begin
      if (rdy) begin
        mIfPc  = mPc;
        mInstr = data;
        mValid = 1'b1;
        mPc    = mPc + 64'd4;
        mFetched++;
      end else begin
        mValid = 1'b0;
        mBubbles++;
      end
    end else if (rdy) begin
      holdQ.push_back({mPc, data});
      mPc = mPc + 64'd4;
    end
  endtask

  // Drive one cycle of inputs and queue the state the DUT must show after the next edge.
  task automatic applyStimulus(input logic s, input logic br, input logic [63:0] tgt,
                               input logic rdy, input logic [31:0] data);
    @(negedge clock);
    reset         = 1'b1;
    mInReset      = 1'b0;
    stall         = s;
    PCSrc         = br;
    branch_target = tgt;
    imem_ready    = rdy;
    imem_rdata    = data;
    modelStep(s, br, tgt, rdy, data);
    expQ.push_back(modelSnap());
  endtask

  // Assert reset for one cycle and confirm the outputs drop without waiting for a clock edge.
  task automatic doReset();
    @(negedge clock);
    reset      = 1'b0;
    stall      = 1'b0;
    PCSrc      = 1'b0;
    imem_ready = 1'b0;
    #1;
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    checkOutput("rst_imem_req", {63'h0, imem_req}, 64'h0);
    checkOutput("rst_if_id_pc", if_id_pc, 64'h0);
    checkOutput("rst_if_id_pc_plus4", if_id_pc_plus4, 64'h4);
    checkOutput("rst_if_id_instr", {32'h0, if_id_instruction}, 64'h0);
    checkOutput("rst_if_id_valid", {63'h0, if_id_valid}, 64'h0);
    mInReset = 1'b1;
    modelReset();
    expQ.push_back(modelSnap());
  endtask

  // Monitor: after every rising edge, pop the expected snapshot and compare all outputs.
  initial begin
    snap_t e;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("imem_addr", imem_addr, e.pc);
        checkOutput("imem_req", {63'h0, imem_req}, {63'h0, e.req});
        checkOutput("if_id_valid", {63'h0, if_id_valid}, {63'h0, e.valid});
        checkOutput("if_id_pc", if_id_pc, e.ifPc);
        checkOutput("if_id_pc_plus4", if_id_pc_plus4, e.ifPc + 64'd4);
        checkOutput("if_id_instruction", {32'h0, if_id_instruction}, {32'h0, e.instr});
`ifdef IFETCH_PERF_EN
        checkOutput("perf_fetched", {32'h0, perf_fetched}, {32'h0, e.fetched});
        checkOutput("perf_bubbles", {32'h0, perf_bubbles}, {32'h0, e.bubbles});
        checkOutput("perf_flushes", {32'h0, perf_flushes}, {32'h0, e.flushes});
`endif
      end
    end
  end

  // Stimulus: directed scenarios first, then a long randomized run with a mid-stream reset.
  initial begin
    logic [63:0] tgt;
    int          budget;
    mInReset = 1'b1;
    modelReset();
    doReset();

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, $urandom);

    applyStimulus(1'b0, 1'b1, 64'h10, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, $urandom);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 32'h1234_5678);

    applyStimulus(1'b0, 1'b1, 64'h20, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 32'h8B02_0020);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, $urandom);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, $urandom);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, $urandom);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, $urandom);

    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, $urandom);
    applyStimulus(1'b1, 1'b1, 64'h1003, 1'b1, $urandom);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, $urandom);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, $urandom);

    applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, $urandom);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, $urandom);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, $urandom);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      if ($urandom_range(3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      else tgt = {$urandom, $urandom};
      applyStimulus($urandom_range(2) == 0, $urandom_range(9) == 0, tgt,
                    $urandom_range(3) != 0, $urandom);
    end
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 32'h0);

    budget = 0;
    while (expQ.size() != 0 && budget < 20) begin
      @(posedge clock);
      budget++;
    end
    #2;
    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the pipelined ARMv8 core: owns the program counter, issues instruction-memory requests, and loads the IF/ID pipeline register consumed by the decode stage. It advances by 4 bytes per accepted instruction, redirects to a branch target when the branch is taken, and stalls on hazard-unit requests. A one-entry hold buffer absorbs an instruction that returns from memory while the stage is stalled.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- PCSrc  in  1  branch taken: redirect and flush.
- branch_target  in  64  redirect address; bits [1:0] ignored and treated as 0.
- imem_addr  out  64  fetch address, always equals the PC register.
- imem_req  out  1  fetch request.
- imem_ready  in  1  imem_rdata valid this cycle for imem_addr.
- imem_rdata  in  32  instruction word.
- if_id_pc  out  64  PC of the instruction in IF/ID.
- if_id_pc_plus4  out  64  if_id_pc + 4; becomes the link value (PC_branch_link) for BL.
- if_id_instruction  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction (0 means bubble).
- With IFETCH_PERF_EN only: perf_fetched, perf_bubbles, perf_flushes, each out, 32 bits.

## Operation
- States are RUN and HELD. Reset enters RUN.
- In RUN, imem_req = 1. In HELD, imem_req = 0.
- Priority per cycle is PCSrc, then stall, then normal operation.
- PCSrc = 1, in any state and regardless of stall:
  - PC <= {branch_target[63:2], 2'b00}.
  - if_id_valid <= 0. The other IF/ID fields hold.
  - The hold buffer is discarded and the state goes to RUN.
  - An imem_ready in the same cycle is ignored.
- RUN, stall = 0, imem_ready = 1: IF/ID <= {PC, PC+4, imem_rdata, valid = 1} and PC <= PC+4.
- RUN, stall = 0, imem_ready = 0: if_id_valid <= 0 (bubble) and the PC holds.
- RUN, stall = 1, imem_ready = 1: imem_rdata and PC are stored in the hold buffer, PC <= PC+4, and the state goes to HELD. IF/ID holds.
- RUN, stall = 1, imem_ready = 0: everything holds.
- HELD, stall = 1: everything holds.
- HELD, stall = 0: IF/ID <= hold buffer (valid = 1) and the state goes to RUN.
- PC arithmetic is 64-bit unsigned. PC+4 wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).

## Timing
- Reset values:
  - PC and imem_addr = RESET_PC; imem_req = 1 after reset release (0 while reset is low).
  - if_id_pc = 0, if_id_pc_plus4 = 4, if_id_instruction = 32'h0, if_id_valid = 0.
  - Performance counters = 0; state = RUN.
- Memory access is single-cycle combinational: the request and response occur in the same cycle as imem_ready. Wait states are imem_ready = 0 cycles.
- Latency: an instruction accepted in cycle n is visible on the IF/ID outputs in cycle n+1. Through HELD, it appears in the cycle after stall deasserts.
- Redirect: the PC equals the target in the cycle after PCSrc. The first target instruction is in IF/ID at the earliest 2 cycles after PCSrc.
- Reset asserted mid-operation asynchronously forces all reset values, including dropping a HELD entry.

## Configuration
- IFETCH_PERF_EN defined: three wrap-around 32-bit counters and their output ports are built.
  - perf_fetched increments on each valid load into IF/ID.
  - perf_bubbles increments on each RUN cycle with stall = 0, imem_ready = 0 and PCSrc = 0.
  - perf_flushes increments on each PCSrc = 1 cycle.
- IFETCH_PERF_EN undefined: the counters and ports are absent. Fetch behaviour is identical either way.

## Test plan
- Reset with RESET_PC = 64'h400, then imem_ready held at 1 -> imem_addr steps 0x400, 0x404, 0x408; if_id_pc lags one cycle; if_id_pc_plus4 = 0x404 when if_id_pc = 0x400.
- imem_ready low for 3 cycles at PC 0x10 -> 3 cycles with if_id_valid = 0, PC stays 0x10, and perf_bubbles = 3 when IFETCH_PERF_EN is defined.
- stall = 1 with imem_ready = 1 at PC 0x20 (rdata 0x8B020020), stall held 2 more cycles -> imem_req = 0 in HELD; after stall drops, IF/ID = {0x20, 0x8B020020, valid}; PC = 0x24.
- PCSrc = 1 with branch_target 0x1003 while in HELD -> PC = 0x1000, if_id_valid = 0, state RUN, hold buffer discarded.
- PC = 64'hFFFF_FFFF_FFFF_FFFC fetched -> next PC = 0.
- Reset asserted for 1 cycle mid-stream -> all outputs take reset values immediately, and fetch restarts at RESET_PC.
